// File: rtl/video_timing_sink_if.sv
// ---------------------------------------------------------------------------
// video_timing_sink_if
// Beat stream from the 4-pixel-per-beat video source into video_timing_sink.
//
// Signals:
//   in_valid          source -> sink   beat valid
//   in_ready          sink   -> source beat accepted when in_valid & in_ready
//   in_bits_0..3      source -> sink   pixels x+0..x+3, RGB in [23:0]
//
// Modports:
//   master  the pixel source
//   slave   the timing sink
// ---------------------------------------------------------------------------
interface video_timing_sink_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bits_0;
    logic [63:0] in_bits_1;
    logic [63:0] in_bits_2;
    logic [63:0] in_bits_3;

    modport master (
        output in_valid, in_bits_0, in_bits_1, in_bits_2, in_bits_3,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_bits_0, in_bits_1, in_bits_2, in_bits_3,
        output in_ready
    );
endinterface

// File: rtl/video_timing_sink.sv
// ---------------------------------------------------------------------------
// video_timing_sink
// Raster timing generator and pixel sink in front of the TMDS encoder.
// Horizontal timing runs in 4-pixel beats, vertical timing in lines. One beat
// is pulled from the source per active cycle; stale beats left over after the
// active area are drained during vertical blanking so the source lines up
// with the next start_frame.
//
// Ports:
//   clock, reset            pixel-group clock, asynchronous active-low reset
//   enable                  run raster (stop is honoured only at frame end)
//   h_* / v_*               timing (horizontal in pixels, vertical in lines)
//   h_sync_pol, v_sync_pol  1 = active-high sync
//   clear_status            clears sticky flags
//   start_frame             one-cycle pulse requesting the next frame
//   bus (slave)             in_valid / in_ready / in_bits_0..3
//   out_de, out_hsync, out_vsync, out_pixel_0..3   registered video outputs
//   underflow, overflow     sticky status
//
// Optional feature, macro VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN:
//   adds underflow_count[15:0] (saturating) and outputs magenta for
//   underflowed beats instead of black.
// ---------------------------------------------------------------------------
module video_timing_sink #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] h_active,
    input  logic [CNT_W-1:0] h_front,
    input  logic [CNT_W-1:0] h_sync,
    input  logic [CNT_W-1:0] h_back,
    input  logic [CNT_W-1:0] v_active,
    input  logic [CNT_W-1:0] v_front,
    input  logic [CNT_W-1:0] v_sync,
    input  logic [CNT_W-1:0] v_back,
    input  logic             h_sync_pol,
    input  logic             v_sync_pol,
    input  logic             clear_status,
    output logic             start_frame,
    video_timing_sink_if.slave bus,
    output logic             out_de,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic [23:0]      out_pixel_0,
    output logic [23:0]      out_pixel_1,
    output logic [23:0]      out_pixel_2,
    output logic [23:0]      out_pixel_3,
    output logic             underflow,
`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
    output logic [15:0]      underflow_count,
`endif
    output logic             overflow
);

`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
    localparam logic [23:0] UF_PIXEL = 24'hFF00FF;
`else
    localparam logic [23:0] UF_PIXEL = 24'h000000;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] hcount, vcount, hcount_next, vcount_next;
    logic             start_next;

    logic [CNT_W-1:0] ha, hf, hs, hb, ht, vt, h_last, v_last;
    logic             h_end, v_end, active, flush;
    logic             hsync_region, vsync_region, uf_set, of_set;
    logic             unused_upper;

    // Horizontal fields in beats; the low two pixel bits are dropped.
    assign ha     = h_active >> 2;
    assign hf     = h_front  >> 2;
    assign hs     = h_sync   >> 2;
    assign hb     = h_back   >> 2;
    assign ht     = ha + hf + hs + hb;
    assign vt     = v_active + v_front + v_sync + v_back;
    assign h_last = ht - CNT_W'(1);
    assign v_last = vt - CNT_W'(1);
    assign h_end  = (hcount == h_last);
    assign v_end  = (vcount == v_last);

    // Active area pulls beats; the flush window (vertical blanking except the
    // last line) accepts and discards anything the source still holds. The
    // last line is kept closed so the source can prime the next frame after
    // start_frame without losing its first beat.
    assign active = (state == RUN) && (vcount < v_active) && (hcount < ha);
    assign flush  = (state == RUN) && (vcount >= v_active) && (vcount < v_last);

    assign bus.in_ready = (state == IDLE) || active || flush;

    assign hsync_region = (hcount >= ha + hf) && (hcount < ha + hf + hs);
    assign vsync_region = (vcount >= v_active + v_front) &&
                          (vcount < v_active + v_front + v_sync);

    assign uf_set = active && !bus.in_valid;
    assign of_set = flush && bus.in_valid;

    assign unused_upper = ^{bus.in_bits_0[63:24], bus.in_bits_1[63:24],
                            bus.in_bits_2[63:24], bus.in_bits_3[63:24]};

    // Next-state and counter logic. Entering a frame parks the counters on
    // the last line so start_frame always coincides with (0, VT-1), both on
    // the first frame and on every wrap. A stop request only takes effect on
    // the final beat of a frame.
    always_comb begin
        state_next  = state;
        hcount_next = hcount;
        vcount_next = vcount;
        start_next  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next  = RUN;
                    hcount_next = '0;
                    vcount_next = v_last;
                    start_next  = 1'b1;
                end
            end
            RUN: begin
                if (h_end && v_end && !enable) begin
                    state_next  = IDLE;
                    hcount_next = '0;
                    vcount_next = '0;
                end else begin
                    if (h_end) begin
                        hcount_next = '0;
                        vcount_next = v_end ? '0 : vcount + CNT_W'(1);
                    end else begin
                        hcount_next = hcount + CNT_W'(1);
                    end
                    start_next = (hcount_next == '0) && (vcount_next == v_last);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and all registered outputs. Pixels are captured in the
    // accepting cycle so they stay aligned with out_de; sync levels fall back
    // to the inactive polarity whenever the raster is stopped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hcount      <= '0;
            vcount      <= '0;
            start_frame <= 1'b0;
            out_de      <= 1'b0;
            out_hsync   <= 1'b0;
            out_vsync   <= 1'b0;
            out_pixel_0 <= '0;
            out_pixel_1 <= '0;
            out_pixel_2 <= '0;
            out_pixel_3 <= '0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            hcount      <= hcount_next;
            vcount      <= vcount_next;
            start_frame <= start_next;
            out_de      <= active;
            if (active) begin
                out_pixel_0 <= bus.in_valid ? bus.in_bits_0[23:0] : UF_PIXEL;
                out_pixel_1 <= bus.in_valid ? bus.in_bits_1[23:0] : UF_PIXEL;
                out_pixel_2 <= bus.in_valid ? bus.in_bits_2[23:0] : UF_PIXEL;
                out_pixel_3 <= bus.in_valid ? bus.in_bits_3[23:0] : UF_PIXEL;
            end else begin
                out_pixel_0 <= '0;
                out_pixel_1 <= '0;
                out_pixel_2 <= '0;
                out_pixel_3 <= '0;
            end
            if (state == RUN) begin
                out_hsync <= hsync_region ~^ h_sync_pol;
                out_vsync <= vsync_region ~^ v_sync_pol;
            end else begin
                out_hsync <= ~h_sync_pol;
                out_vsync <= ~v_sync_pol;
            end
            // A set in the same cycle as clear_status wins.
            underflow <= uf_set | (underflow & ~clear_status);
            overflow  <= of_set | (overflow & ~clear_status);
        end
    end

`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
    // Saturating count of underflowed beats; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underflow_count <= '0;
        end else if (clear_status) begin
            underflow_count <= '0;
        end else if (uf_set && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_sink.sv
// ---------------------------------------------------------------------------
// tb_video_timing_sink
// Directed bench for video_timing_sink with a cycle model of the raster and a
// scoreboard of accepted beats. Timing: HA=4 HF=1 HS=2 HB=1 (HT=8 beats),
// v_active=3 v_front=1 v_sync=1 v_back=1 (VT=6), both syncs active-high.
// ---------------------------------------------------------------------------
module tb_video_timing_sink;

    localparam int HA  = 4;
    localparam int HT  = 8;
    localparam int HSB = 5;
    localparam int HSE = 7;
    localparam int VA  = 3;
    localparam int VT  = 6;
    localparam int VSL = 4;
    localparam int BEATS_PER_FRAME = 12;

`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
    localparam logic [23:0] UF_PIX = 24'hFF00FF;
`else
    localparam logic [23:0] UF_PIX = 24'h000000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] h_active, h_front, h_sync, h_back;
    logic [15:0] v_active, v_front, v_sync, v_back;
    logic        h_sync_pol, v_sync_pol, clear_status;
    logic        start_frame, out_de, out_hsync, out_vsync;
    logic [23:0] out_pixel_0, out_pixel_1, out_pixel_2, out_pixel_3;
    logic        underflow, overflow;
`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
    logic [15:0] underflow_count;
`endif

    video_timing_sink_if bus();

    video_timing_sink #(.CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .h_active     (h_active),
        .h_front      (h_front),
        .h_sync       (h_sync),
        .h_back       (h_back),
        .v_active     (v_active),
        .v_front      (v_front),
        .v_sync       (v_sync),
        .v_back       (v_back),
        .h_sync_pol   (h_sync_pol),
        .v_sync_pol   (v_sync_pol),
        .clear_status (clear_status),
        .start_frame  (start_frame),
        .bus          (bus.slave),
        .out_de       (out_de),
        .out_hsync    (out_hsync),
        .out_vsync    (out_vsync),
        .out_pixel_0  (out_pixel_0),
        .out_pixel_1  (out_pixel_1),
        .out_pixel_2  (out_pixel_2),
        .out_pixel_3  (out_pixel_3),
        .underflow    (underflow),
`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
        .underflow_count (underflow_count),
`endif
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Source and scoreboard state
    logic [15:0] src_q[$];
    logic [95:0] exp_q[$];
    logic [15:0] next_seq = 16'h0100;
    int          extra = 0;
    bit          gap_en = 1'b0;
    bit          starve = 1'b0;

    // Raster model
    bit          m_run, m_sf, m_de, m_uf, m_of;
    int          hc, vc;
    int          m_cnt;

    function automatic logic [23:0] pix(input logic [15:0] seq, input int i);
        return {seq, 8'(i)};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_sf = 1'b0; m_de = 1'b0; m_uf = 1'b0; m_of = 1'b0;
        hc = 0; vc = 0; m_cnt = 0;
    endtask

    // Present the head of the source queue, unless a gap is being forced.
    task automatic drive_src();
        logic [15:0] seq;
        bit gap;
        gap = starve || (gap_en && m_run && vc == 1 && hc == 2);
        seq = (src_q.size() > 0) ? src_q[0] : 16'h0;
        bus.in_valid  = (src_q.size() > 0) && !gap;
        bus.in_bits_0 = {40'hBAD0BAD0BA, pix(seq, 0)};
        bus.in_bits_1 = {40'hBAD0BAD0BA, pix(seq, 1)};
        bus.in_bits_2 = {40'hBAD0BAD0BA, pix(seq, 2)};
        bus.in_bits_3 = {40'hBAD0BAD0BA, pix(seq, 3)};
    endtask

    // One clock: check the combinational outputs, score the handshake,
    // advance the model, then check every registered output after the edge.
    task automatic tick();
        bit act, fl, rdy, acc, uf_set, of_set, nsf, nde, nhs, nvs;
        logic [95:0] px;
        act = m_run && vc < VA && hc < HA;
        fl  = m_run && vc >= VA && vc < VT - 1;
        rdy = !m_run || act || fl;
        chk1("in_ready", bus.in_ready, rdy);
        chk1("start_frame", start_frame, m_sf);
        acc    = bus.in_valid && rdy;
        uf_set = act && !bus.in_valid;
        of_set = fl && bus.in_valid;
        if (act)
            exp_q.push_back(bus.in_valid ?
                {bus.in_bits_3[23:0], bus.in_bits_2[23:0], bus.in_bits_1[23:0], bus.in_bits_0[23:0]} :
                {UF_PIX, UF_PIX, UF_PIX, UF_PIX});
        nde = act;
        nhs = m_run && hc >= HSB && hc < HSE;
        nvs = m_run && vc == VSL;
        nsf = 1'b0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1'b1; hc = 0; vc = VT - 1; nsf = 1'b1;
            end
        end else if (hc == HT - 1 && vc == VT - 1 && !enable) begin
            m_run = 1'b0; hc = 0; vc = 0;
        end else begin
            hc++;
            if (hc == HT) begin
                hc = 0;
                vc = (vc == VT - 1) ? 0 : vc + 1;
            end
            nsf = (hc == 0 && vc == VT - 1);
        end
        m_uf = uf_set || (m_uf && !clear_status);
        m_of = of_set || (m_of && !clear_status);
        if (clear_status) m_cnt = 0;
        else if (uf_set && m_cnt != 16'hFFFF) m_cnt++;

        @(posedge clock);
        #1;
        m_sf = nsf;
        m_de = nde;
        if (acc) void'(src_q.pop_front());
        chk1("out_de", out_de, nde);
        chk1("out_hsync", out_hsync, nhs);
        chk1("out_vsync", out_vsync, nvs);
        chk1("underflow", underflow, m_uf);
        chk1("overflow", overflow, m_of);
        px = '0;
        if (nde) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("[TB] FAIL scoreboard_empty observed=de expected=beat");
            end else begin
                px = exp_q.pop_front();
            end
        end
        chkv("pixels", {out_pixel_3, out_pixel_2, out_pixel_1, out_pixel_0}, px);
`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
        chkv("underflow_count", 96'(underflow_count), 96'(m_cnt));
`endif
        // The source answers start_frame with one frame of beats.
        if (start_frame) begin
            for (int b = 0; b < BEATS_PER_FRAME + extra; b++) begin
                src_q.push_back(next_seq);
                next_seq++;
            end
            extra = 0;
        end
        drive_src();
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the model sits on a start_frame cycle (bounded).
    task automatic wait_frame_start();
        int guard;
        guard = 0;
        while (!m_sf && guard < 200) begin
            tick();
            guard++;
        end
        if (!m_sf) begin
            miscompares++;
            $error("[TB] FAIL frame_start_timeout observed=none expected=start_frame");
        end
    endtask

    task automatic checkOutput_all_zero(input string tag);
        chk1({tag, "_start_frame"}, start_frame, 1'b0);
        chk1({tag, "_de"}, out_de, 1'b0);
        chk1({tag, "_hsync"}, out_hsync, 1'b0);
        chk1({tag, "_vsync"}, out_vsync, 1'b0);
        chk1({tag, "_underflow"}, underflow, 1'b0);
        chk1({tag, "_overflow"}, overflow, 1'b0);
        chkv({tag, "_pixels"}, {out_pixel_3, out_pixel_2, out_pixel_1, out_pixel_0}, 96'h0);
    endtask

    initial begin
        int guard;
        reset = 1'b0;
        enable = 1'b0;
        clear_status = 1'b0;
        h_active = 16'd16; h_front = 16'd4; h_sync = 16'd8; h_back = 16'd4;
        v_active = 16'd3;  v_front = 16'd1; v_sync = 16'd1; v_back = 16'd1;
        h_sync_pol = 1'b1; v_sync_pol = 1'b1;
        model_reset();
        drive_src();
        #12;
        $display("[TB] reset state");
        checkOutput_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Idle cycles, then two clean frames
        applyStimulus(4);
        $display("[TB] clean frames");
        enable = 1'b1;
        applyStimulus(2 * VT * HT + 4);

        // One missing beat at line 1, beat 2
        $display("[TB] underflow gap");
        wait_frame_start();
        gap_en = 1'b1;
        applyStimulus(VT * HT);
        gap_en = 1'b0;
        chk1("underflow_after_gap", underflow, 1'b1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk1("underflow_cleared", underflow, 1'b0);

        // Two extra beats beyond the frame get flushed
        $display("[TB] overflow flush");
        extra = 2;
        wait_frame_start();
        applyStimulus(2 * VT * HT);
        chk1("overflow_after_extra", overflow, 1'b1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;

        // Stop mid-frame: the frame completes, then idle
        $display("[TB] enable drop");
        guard = 0;
        while (!(m_run && vc == 1) && guard < 200) begin
            tick();
            guard++;
        end
        enable = 1'b0;
        guard = 0;
        while (m_run && guard < 200) begin
            tick();
            guard++;
        end
        applyStimulus(3 * VT * HT);
        chk1("idle_ready", bus.in_ready, 1'b1);
        chk1("idle_hsync", out_hsync, 1'b0);

        // Asynchronous reset while DE is high
        $display("[TB] async reset mid-line");
        enable = 1'b1;
        guard = 0;
        while (!m_de && guard < 200) begin
            tick();
            guard++;
        end
        chk1("de_before_reset", out_de, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput_all_zero("async_reset");
        src_q.delete();
        exp_q.delete();
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive_src();
        tick();
        chk1("first_start_after_reset", start_frame, 1'b1);
        applyStimulus(VT * HT + 4);

`ifdef VIDEO_TIMING_SINK_UNDERFLOW_COUNT_EN
        // Whole frame starved: 12 magenta beats counted
        $display("[TB] underflow count");
        wait_frame_start();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        starve = 1'b1;
        drive_src();
        applyStimulus(VT * HT);
        chkv("underflow_count_frame", 96'(underflow_count), 96'(12));
        starve = 1'b0;
        drive_src();
        applyStimulus(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
